// File: rtl/trigger_event_reader_if.sv
// Handshake bundle for trigger_event_reader.
// Groups the event FIFO read port, the framed 32-bit output stream and
// the status counters.
interface trigger_event_reader_if;
  logic        enable;
  logic        fifo_empty;
  logic [17:0] fifo_q;
  logic        fifo_re;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] event_count;
  logic [7:0]  error_count;

  modport master (
    input  enable, fifo_empty, fifo_q, out_ready,
    output fifo_re, out_data, out_valid, out_last, event_count, error_count
  );

  modport slave (
    output enable, fifo_empty, fifo_q, out_ready,
    input  fifo_re, out_data, out_valid, out_last, event_count, error_count
  );
endinterface

// File: rtl/trigger_event_reader.sv
// trigger_event_reader: drains the 18-bit tagged event FIFO and emits framed
// 32-bit words (header W0/W1, packed sample pairs, trailer with sample count).
// Optional feature macro: TRIGGER_READER_TIMESTAMP_EN adds a free-running
// cycle counter whose value at header capture is sent as a third preamble word.
module trigger_event_reader #(
  parameter int unsigned MAX_EVENT_WORDS = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  trigger_event_reader_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, SEND, DRAIN_FETCH, DRAIN_CAPTURE
  } state_t;

  localparam logic [1:0]  TAG_SMP = 2'b00;
  localparam logic [1:0]  TAG_HDR = 2'b10;
  localparam logic [1:0]  TAG_TRL = 2'b11;
  localparam logic [15:0] MAX_W   = MAX_EVENT_WORDS[15:0];

  // Pending output word flags, emitted lowest index first.
  localparam int unsigned W_PAD  = 0;
  localparam int unsigned W_TRL  = 1;
  localparam int unsigned W_H0   = 2;
  localparam int unsigned W_H1   = 3;
  localparam int unsigned W_TS   = 4;
  localparam int unsigned W_PAIR = 5;

  state_t      state_q, state_d;
  logic        fifo_re_q, fifo_re_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [15:0] event_count_q, event_count_d;
  logic [7:0]  error_count_q, error_count_d;
  logic        in_event_q, in_event_d;
  logic        drain_q, drain_d;
  logic [15:0] sample_count_q, sample_count_d;
  logic        half_q, half_d;
  logic [15:0] low_q, low_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] hdr_q, hdr_d;
  logic [15:0] trl_hi_q, trl_hi_d;
  logic [15:0] trl_cnt_q, trl_cnt_d;
  logic [5:0]  pend_q, pend_d;
`ifdef TRIGGER_READER_TIMESTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] ts_q, ts_d;
`endif

  logic        xfer;
  logic        load;
  logic        err_inc;
  logic [1:0]  tag;
  logic [15:0] pay;

  assign xfer = out_valid_q & bus.out_ready;
  assign tag  = bus.fifo_q[17:16];
  assign pay  = bus.fifo_q[15:0];

  // Next-state, frame building and output word selection.
  always_comb begin
    state_d        = state_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_last_d     = out_last_q;
    event_count_d  = event_count_q;
    in_event_d     = in_event_q;
    drain_d        = drain_q;
    sample_count_d = sample_count_q;
    half_d         = half_q;
    low_d          = low_q;
    hi_d           = hi_q;
    hdr_d          = hdr_q;
    trl_hi_d       = trl_hi_q;
    trl_cnt_d      = trl_cnt_q;
    pend_d         = pend_q;
`ifdef TRIGGER_READER_TIMESTAMP_EN
    ts_d           = ts_q;
`endif
    load           = 1'b0;
    err_inc        = 1'b0;

    if (xfer && out_last_q) event_count_d = event_count_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (drain_q) begin
          if (!bus.fifo_empty) state_d = DRAIN_FETCH;
        end else if ((bus.enable || in_event_q) && !bus.fifo_empty) begin
          state_d = FETCH;
        end
      end

      FETCH:       state_d = CAPTURE;
      DRAIN_FETCH: state_d = DRAIN_CAPTURE;

      DRAIN_CAPTURE: begin
        if (tag == TAG_TRL) begin
          drain_d = 1'b0;
          state_d = IDLE;
        end else if (!bus.fifo_empty) begin
          state_d = DRAIN_FETCH;
        end else begin
          state_d = IDLE;
        end
      end

      CAPTURE: begin
        state_d = SEND;
        load    = 1'b1;
        if (!in_event_q) begin
          if (tag == TAG_HDR) begin
            hdr_d          = pay;
            sample_count_d = '0;
            half_d         = 1'b0;
            in_event_d     = 1'b1;
            pend_d[W_H0]   = 1'b1;
            pend_d[W_H1]   = 1'b1;
`ifdef TRIGGER_READER_TIMESTAMP_EN
            pend_d[W_TS]   = 1'b1;
            ts_d           = cycle_q;
`endif
          end else begin
            err_inc = 1'b1;
            load    = 1'b0;
            state_d = IDLE;
          end
        end else begin
          case (tag)
            TAG_HDR: begin
              // Close the open frame (pad + truncated trailer, old count is
              // frozen into trl_cnt), then open the new one.
              pend_d[W_PAD]  = half_q;
              pend_d[W_TRL]  = 1'b1;
              trl_hi_d       = 16'hEEFE;
              trl_cnt_d      = sample_count_q;
              err_inc        = 1'b1;
              hdr_d          = pay;
              sample_count_d = '0;
              half_d         = 1'b0;
              pend_d[W_H0]   = 1'b1;
              pend_d[W_H1]   = 1'b1;
`ifdef TRIGGER_READER_TIMESTAMP_EN
              pend_d[W_TS]   = 1'b1;
              ts_d           = cycle_q;
`endif
            end
            TAG_SMP: begin
              if (sample_count_q >= MAX_W) begin
                pend_d[W_PAD] = half_q;
                pend_d[W_TRL] = 1'b1;
                trl_hi_d      = 16'hEEFE;
                trl_cnt_d     = sample_count_q;
                half_d        = 1'b0;
                err_inc       = 1'b1;
                in_event_d    = 1'b0;
                drain_d       = 1'b1;
              end else begin
                sample_count_d = sample_count_q + 16'd1;
                if (half_q) begin
                  hi_d           = pay;
                  half_d         = 1'b0;
                  pend_d[W_PAIR] = 1'b1;
                end else begin
                  low_d  = pay;
                  half_d = 1'b1;
                end
              end
            end
            TAG_TRL: begin
              pend_d[W_PAD] = half_q;
              pend_d[W_TRL] = 1'b1;
              trl_hi_d      = 16'hEEFF;
              trl_cnt_d     = sample_count_q;
              half_d        = 1'b0;
              in_event_d    = 1'b0;
            end
            default: err_inc = 1'b1;
          endcase
        end
      end

      SEND: begin
        if (!out_valid_q || xfer) begin
          load = 1'b1;
          if (pend_q == '0) begin
            if (drain_q) begin
              state_d = bus.fifo_empty ? IDLE : DRAIN_FETCH;
            end else if ((bus.enable || in_event_q) && !bus.fifo_empty) begin
              state_d = FETCH;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Present the highest-priority pending word; drop valid if none remain.
    if (load) begin
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      if (pend_d[W_PAD]) begin
        out_data_d    = {16'h0000, low_d};
        pend_d[W_PAD] = 1'b0;
      end else if (pend_d[W_TRL]) begin
        out_data_d    = {trl_hi_d, trl_cnt_d};
        out_last_d    = 1'b1;
        pend_d[W_TRL] = 1'b0;
      end else if (pend_d[W_H0]) begin
        out_data_d   = {16'hEE01, event_count_d};
        pend_d[W_H0] = 1'b0;
      end else if (pend_d[W_H1]) begin
        out_data_d   = {16'h0000, hdr_d};
        pend_d[W_H1] = 1'b0;
`ifdef TRIGGER_READER_TIMESTAMP_EN
      end else if (pend_d[W_TS]) begin
        out_data_d   = ts_d;
        pend_d[W_TS] = 1'b0;
`endif
      end else if (pend_d[W_PAIR]) begin
        out_data_d     = {hi_d, low_d};
        pend_d[W_PAIR] = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    error_count_d = (err_inc && (error_count_q != 8'hFF)) ? error_count_q + 8'd1
                                                          : error_count_q;
    fifo_re_d     = (state_d == FETCH) || (state_d == DRAIN_FETCH);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      fifo_re_q      <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      event_count_q  <= '0;
      error_count_q  <= '0;
      in_event_q     <= 1'b0;
      drain_q        <= 1'b0;
      sample_count_q <= '0;
      half_q         <= 1'b0;
      low_q          <= '0;
      hi_q           <= '0;
      hdr_q          <= '0;
      trl_hi_q       <= '0;
      trl_cnt_q      <= '0;
      pend_q         <= '0;
    end else begin
      state_q        <= state_d;
      fifo_re_q      <= fifo_re_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      event_count_q  <= event_count_d;
      error_count_q  <= error_count_d;
      in_event_q     <= in_event_d;
      drain_q        <= drain_d;
      sample_count_q <= sample_count_d;
      half_q         <= half_d;
      low_q          <= low_d;
      hi_q           <= hi_d;
      hdr_q          <= hdr_d;
      trl_hi_q       <= trl_hi_d;
      trl_cnt_q      <= trl_cnt_d;
      pend_q         <= pend_d;
    end
  end

`ifdef TRIGGER_READER_TIMESTAMP_EN
  // Free-running cycle counter and header-time snapshot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_q <= '0;
      ts_q    <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      ts_q    <= ts_d;
    end
  end
`endif

  assign bus.fifo_re     = fifo_re_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.event_count = event_count_q;
  assign bus.error_count = error_count_q;

endmodule
